// File: rtl/cam_pkg.sv
// Shared definitions for the camera pixel capture path: FSM state encoding,
// pixel width and default frame geometry, plus the byte-to-pixel packing helper.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    VBLANK  = 3'd2,
    ACTIVE  = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } cap_state_t;

  localparam int RGB565_W  = 16;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  // Joins the two camera bytes of one pixel; swap selects which byte lands in the high half.
  function automatic logic [RGB565_W-1:0] pack_pixel(input logic [7:0] first_byte,
                                                     input logic [7:0] second_byte,
                                                     input logic       swap);
    return swap ? {second_byte, first_byte} : {first_byte, second_byte};
  endfunction

endpackage

// File: rtl/pix_out_reg.sv
// Single-entry valid/ready holding register. The camera cannot be stalled, so a
// new pixel arriving while the held one is still waiting is dropped and flagged.
module pix_out_reg
  import cam_pkg::*;
#(
  parameter int DW = RGB565_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_drop
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          w_take;

  // A new pixel fits when the register is empty or is being emptied this same cycle.
  assign w_take = i_load & (~r_valid | i_ready);
  assign o_drop = i_load & r_valid & ~i_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;

  // Load on a fitting pixel, otherwise retire the held pixel once the consumer takes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid & i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cam_pixel_capture.sv
// Converts the synchronised camera byte bus into a 16-bit pixel stream for one
// frame per arm, pulsing frame_start for the downstream stream buffer and
// flagging overflow and frame-geometry errors.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int CNT_W     = 12,
  parameter int BYTE_SWAP = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_arm,
  input  logic                i_cam_vsync,
  input  logic                i_cam_href,
  input  logic [7:0]          i_cam_byte,
  input  logic                i_cam_byte_valid,
  output logic [RGB565_W-1:0] o_pix_data,
  output logic                o_pix_valid,
  input  logic                i_pix_ready,
  output logic                o_frame_start,
  output logic                o_frame_done,
  output logic                o_busy,
  output logic                o_err_overflow,
  output logic                o_err_geom
);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_WAIT_VS = WAIT_VS;
  localparam logic [2:0] S_VBLANK  = VBLANK;
  localparam logic [2:0] S_ACTIVE  = ACTIVE;
  localparam logic [2:0] S_DRAIN   = DRAIN;
  localparam logic [2:0] S_DONE    = DONE;

  localparam logic [CNT_W-1:0] W_LIM   = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] H_LIM   = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic                r_vsync_d;
  logic                r_href_d;
  logic [CNT_W-1:0]    r_line_cnt;
  logic [CNT_W-1:0]    r_pix_cnt;
  logic                r_phase;
  logic [7:0]          r_byte0;
  logic                r_frame_start;
  logic                r_err_overflow;
  logic                r_err_geom;

  logic                w_vs_rise;
  logic                w_href_rise;
  logic                w_href_fall;
  logic                w_active;
  logic                w_byte_acc;
  logic                w_phase_eff;
  logic                w_pix_done;
  logic                w_line_end;
  logic                w_last_line;
  logic                w_drop;
  logic [CNT_W-1:0]    w_line_nxt;
  logic [CNT_W-1:0]    w_pix_nxt;
  logic [RGB565_W-1:0] w_pix_data;

  assign w_vs_rise   = i_cam_vsync & ~r_vsync_d;
  assign w_href_rise = i_cam_href & ~r_href_d;
  assign w_href_fall = ~i_cam_href & r_href_d;
  assign w_active    = (r_state == S_ACTIVE);
  assign w_byte_acc  = w_active & i_cam_href & i_cam_byte_valid;
  assign w_phase_eff = w_href_rise ? 1'b0 : r_phase;
  assign w_pix_done  = w_byte_acc & w_phase_eff & (r_pix_cnt < W_LIM);
  assign w_line_end  = w_active & w_href_fall;
  assign w_line_nxt  = (r_line_cnt == CNT_SAT) ? r_line_cnt : r_line_cnt + 1'b1;
  assign w_pix_nxt   = (r_pix_cnt == CNT_SAT) ? r_pix_cnt : r_pix_cnt + 1'b1;
  assign w_last_line = w_line_end & (w_line_nxt == H_LIM);
  assign w_pix_data  = pack_pixel(r_byte0, i_cam_byte, BYTE_SWAP != 0);

  assign o_busy         = (r_state != S_IDLE);
  assign o_frame_done   = (r_state == S_DONE);
  assign o_frame_start  = r_frame_start;
  assign o_err_overflow = r_err_overflow;
  assign o_err_geom     = r_err_geom;

  pix_out_reg #(
    .DW(RGB565_W)
  ) u_pix_out_reg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_pix_done),
    .i_data  (w_pix_data),
    .i_ready (i_pix_ready),
    .o_data  (o_pix_data),
    .o_valid (o_pix_valid),
    .o_drop  (w_drop)
  );

  // Frame sequencing: wait for a vsync pulse, capture until the last line or an early vsync, then drain.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_arm)                    w_state_nxt = S_WAIT_VS;
      S_WAIT_VS: if (w_vs_rise)                w_state_nxt = S_VBLANK;
      S_VBLANK:  if (!i_cam_vsync)             w_state_nxt = S_ACTIVE;
      S_ACTIVE:  if (w_vs_rise || w_last_line) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (!o_pix_valid)             w_state_nxt = S_DONE;
      S_DONE:                                  w_state_nxt = S_IDLE;
      default:                                 w_state_nxt = S_IDLE;
    endcase
  end

  // State register, sync edge-detect copies and the frame_start pulse on entry to ACTIVE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_vsync_d     <= 1'b0;
      r_href_d      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_vsync_d     <= i_cam_vsync;
      r_href_d      <= i_cam_href;
      r_frame_start <= (r_state == S_VBLANK) & ~i_cam_vsync;
    end
  end

  // Byte pairing and line/pixel counting; everything restarts while waiting in vertical blank.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_line_cnt <= '0;
      r_pix_cnt  <= '0;
      r_phase    <= 1'b0;
      r_byte0    <= '0;
    end else if (r_state == S_VBLANK) begin
      r_line_cnt <= '0;
      r_pix_cnt  <= '0;
      r_phase    <= 1'b0;
    end else if (w_line_end) begin
      r_line_cnt <= w_line_nxt;
      r_pix_cnt  <= '0;
      r_phase    <= 1'b0;
    end else if (w_byte_acc) begin
      if (!w_phase_eff) begin
        r_byte0 <= i_cam_byte;
        r_phase <= 1'b1;
      end else begin
        r_phase   <= 1'b0;
        r_pix_cnt <= w_pix_nxt;
      end
    end else if (w_href_rise) begin
      r_phase <= 1'b0;
    end
  end

  // Sticky error flags, cleared only when a new capture is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_overflow <= 1'b0;
      r_err_geom     <= 1'b0;
    end else if ((r_state == S_IDLE) && i_arm) begin
      r_err_overflow <= 1'b0;
      r_err_geom     <= 1'b0;
    end else begin
      if (w_drop) r_err_overflow <= 1'b1;
      if (w_line_end && ((r_pix_cnt != W_LIM) || r_phase)) r_err_geom <= 1'b1;
      if (w_active && w_vs_rise) r_err_geom <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture with a 4x2 frame; a second instance with
// swapped byte order shares every input so both packings are seen per frame.
module tb_cam_pixel_capture;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;

  logic        clk = 1'b0;
  logic        rst, arm, camVsync, camHref, camByteValid, pixReady;
  logic [7:0]  camByte;
  logic [15:0] pixData, sPixData;
  logic        pixValid, frameStart, frameDone, busy, errOv, errGeom;
  logic        sPixValid, sFrameStart, sFrameDone, sBusy, sErrOv, sErrGeom;

  int checks = 0;
  int failures = 0;
  logic [15:0] pixQ[$];
  logic [15:0] swapQ[$];
  int fsCount = 0;
  int fdCount = 0;
  int pixAtDone = 0;
  int base, fsBase, fdBase;

  logic [15:0] exp3 [5] = '{16'h0102, 16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10};
  logic [15:0] exp4 [7] = '{16'h0102, 16'h0304, 16'h0506, 16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10};

  always #5 clk = ~clk;

  cam_pixel_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(12), .BYTE_SWAP(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_cam_vsync(camVsync), .i_cam_href(camHref),
    .i_cam_byte(camByte), .i_cam_byte_valid(camByteValid), .o_pix_data(pixData),
    .o_pix_valid(pixValid), .i_pix_ready(pixReady), .o_frame_start(frameStart),
    .o_frame_done(frameDone), .o_busy(busy), .o_err_overflow(errOv), .o_err_geom(errGeom)
  );

  cam_pixel_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(12), .BYTE_SWAP(1)) dutSwap (
    .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_cam_vsync(camVsync), .i_cam_href(camHref),
    .i_cam_byte(camByte), .i_cam_byte_valid(camByteValid), .o_pix_data(sPixData),
    .o_pix_valid(sPixValid), .i_pix_ready(pixReady), .o_frame_start(sFrameStart),
    .o_frame_done(sFrameDone), .o_busy(sBusy), .o_err_overflow(sErrOv), .o_err_geom(sErrGeom)
  );

  // Records every accepted pixel and every frame_start/frame_done cycle.
  always @(posedge clk) begin
    if (pixValid && pixReady) pixQ.push_back(pixData);
    if (sPixValid && pixReady) swapQ.push_back(sPixData);
    if (frameStart) fsCount++;
    if (frameDone) begin
      fdCount++;
      pixAtDone = pixQ.size();
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] b, input logic bv);
    camVsync = vs;
    camHref = hr;
    camByte = b;
    camByteValid = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic doArm();
    arm = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    arm = 1'b0;
  endtask

  task automatic sendFrameStart();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic sendLine(input int nBytes, input int firstVal);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < nBytes; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(firstVal + i), 1'b1);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    idle(2);
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  task automatic markFrame();
    base = pixQ.size();
    fsBase = fsCount;
    fdBase = fdCount;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; pixReady = 1'b1;
    camVsync = 1'b0; camHref = 1'b0; camByte = 8'h00; camByteValid = 1'b0;
    idle(2);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pix_valid", 32'(pixValid), 32'd0);
    checkOutput("rst_pix_data", 32'(pixData), 32'd0);
    checkOutput("rst_frame_start", 32'(frameStart), 32'd0);
    checkOutput("rst_frame_done", 32'(frameDone), 32'd0);
    checkOutput("rst_errs", 32'({errOv, errGeom}), 32'd0);
    checkOutput("rst_swap_outs", 32'({sBusy, sFrameStart, sFrameDone}), 32'd0);
    rst = 1'b0;
    idle(1);

    $display("[TB] clean frame, both byte orders");
    markFrame();
    doArm();
    checkOutput("t1_busy_after_arm", 32'(busy), 32'd1);
    sendFrameStart();
    sendLine(8, 1);
    sendLine(8, 9);
    waitIdle("t1_idle");
    checkOutput("t1_pix_count", 32'(pixQ.size() - base), 32'd8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("t1_pix%0d", i), 32'(pixQ[base + i]), 32'({8'(2 * i + 1), 8'(2 * i + 2)}));
    checkOutput("t2_swap_count", 32'(swapQ.size()), 32'd8);
    checkOutput("t2_swap_first", 32'(swapQ[0]), 32'h0201);
    checkOutput("t2_swap_last", 32'(swapQ[7]), 32'h100F);
    checkOutput("t1_frame_start_cycles", 32'(fsCount - fsBase), 32'd1);
    checkOutput("t1_frame_done_cycles", 32'(fdCount - fdBase), 32'd1);
    checkOutput("t1_pix_at_done", 32'(pixAtDone - base), 32'd8);
    checkOutput("t1_errs", 32'({errOv, errGeom}), 32'd0);
    checkOutput("t2_swap_state", 32'({sBusy, sErrOv, sErrGeom}), 32'd0);

    $display("[TB] consumer stalled for line 0");
    pixReady = 1'b0;
    markFrame();
    doArm();
    sendFrameStart();
    sendLine(8, 1);
    checkOutput("t3_held_valid", 32'(pixValid), 32'd1);
    checkOutput("t3_held_data", 32'(pixData), 32'h0102);
    checkOutput("t3_err_overflow", 32'(errOv), 32'd1);
    pixReady = 1'b1;
    sendLine(8, 9);
    waitIdle("t3_idle");
    checkOutput("t3_pix_count", 32'(pixQ.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("t3_pix%0d", i), 32'(pixQ[base + i]), 32'(exp3[i]));
    checkOutput("t3_err_geom", 32'(errGeom), 32'd0);
    checkOutput("t3_frame_done_cycles", 32'(fdCount - fdBase), 32'd1);

    $display("[TB] short line then long line");
    markFrame();
    doArm();
    checkOutput("t4_overflow_cleared", 32'(errOv), 32'd0);
    sendFrameStart();
    sendLine(6, 1);
    checkOutput("t4_geom_short", 32'(errGeom), 32'd1);
    sendLine(10, 9);
    waitIdle("t4_idle");
    checkOutput("t4_pix_count", 32'(pixQ.size() - base), 32'd7);
    for (int i = 0; i < 7; i++)
      checkOutput($sformatf("t4_pix%0d", i), 32'(pixQ[base + i]), 32'(exp4[i]));
    markFrame();
    doArm();
    checkOutput("t4_geom_cleared", 32'(errGeom), 32'd0);
    sendFrameStart();
    sendLine(8, 1);
    sendLine(8, 9);
    waitIdle("t4_clean_idle");
    checkOutput("t4_clean_pix_count", 32'(pixQ.size() - base), 32'd8);
    checkOutput("t4_clean_errs", 32'({errOv, errGeom}), 32'd0);
    checkOutput("t4_clean_done", 32'(fdCount - fdBase), 32'd1);

    $display("[TB] early vsync with ignored arm");
    markFrame();
    doArm();
    sendFrameStart();
    sendLine(8, 1);
    doArm();
    checkOutput("t5_busy_mid", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t5_err_geom", 32'(errGeom), 32'd1);
    waitIdle("t5_idle");
    checkOutput("t5_frame_done_cycles", 32'(fdCount - fdBase), 32'd1);
    checkOutput("t5_pix_count", 32'(pixQ.size() - base), 32'd4);
    idle(2);
    checkOutput("t5_arm_ignored", 32'(busy), 32'd0);
    checkOutput("t5_geom_kept", 32'(errGeom), 32'd1);

    $display("[TB] reset mid-line");
    markFrame();
    doArm();
    sendFrameStart();
    sendLine(8, 1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h09, 1'b1);
    pixReady = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'h0A, 1'b1);
    checkOutput("t6_valid_before_rst", 32'(pixValid), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h0B, 1'b1);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_pix", 32'({pixValid, pixData}), 32'd0);
    checkOutput("t6_rst_flags", 32'({frameStart, frameDone, errOv, errGeom}), 32'd0);
    rst = 1'b0;
    pixReady = 1'b1;
    idle(2);
    markFrame();
    doArm();
    sendFrameStart();
    sendLine(8, 1);
    sendLine(8, 9);
    waitIdle("t6_idle");
    checkOutput("t6_pix_count", 32'(pixQ.size() - base), 32'd8);
    checkOutput("t6_first_pix", 32'(pixQ[base]), 32'h0102);
    checkOutput("t6_last_pix", 32'(pixQ[base + 7]), 32'h0F10);
    checkOutput("t6_errs", 32'({errOv, errGeom}), 32'd0);
    checkOutput("t6_frame_start_cycles", 32'(fsCount - fsBase), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
